dpram_fifo_ctrl: RTL and testbench
==================================

DPRAM_FIFO_CTRL -- requirements
Module: dpram_fifo_ctrl

Interface
REQ-001 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have port rst  input  1  reset: synchronous, active-high.
REQ-003 SHALL have port in_valid  input  1  producer has a nibble.
REQ-004 SHALL have port in_data  input  4  producer nibble.
REQ-005 SHALL have port in_ready  output  1  push accepted when in_valid & in_ready at clk edge; equals (count != 8).
REQ-006 SHALL have port out_valid  output  1  out_data holds the FIFO head.
REQ-007 SHALL have port out_data  output  4  FIFO head; equals mem_d while out_valid=1, 4'h0 otherwise.
REQ-008 SHALL have port out_ready  input  1  pop when out_valid & out_ready at clk edge.
REQ-009 SHALL have port mem_wr_a, mem_addr_a, mem_a  output  1/3/4  memory port A write strobe, address, data.
REQ-010 SHALL have port mem_wr_b, mem_addr_b, mem_b  output  1/3/4  memory port B; mem_wr_b and mem_b tied 0.
REQ-011 SHALL have port mem_d  input  4  memory port B registered read data, one-cycle latency, updated every edge while mem_wr_b=0.
REQ-012 SHALL have ports count (output, 4, stored entries 0..8), full (output, 1, count==8) and empty (output, 1, count==0).
REQ-013 SHALL have ports ovf_err and unf_err  output  1  sticky error flags; present only in effect under FIFO_ERR_FLAGS_EN.

Function
REQ-014 SHALL drive mem_wr_a = in_valid & in_ready, mem_addr_a = wr_ptr and mem_a = in_data combinationally.
REQ-015 SHALL drive mem_addr_b = rd_ptr at all times.
REQ-016 SHALL increment wr_ptr (3-bit, wraps 7->0) on each accepted push.
REQ-017 SHALL increment rd_ptr (3-bit, wraps 7->0) on each accepted pop.
REQ-018 SHALL update count as +1 on push only, -1 on pop only, and unchanged on simultaneous push and pop.
REQ-019 SHALL implement read FSM states IDLE, SHOW and WAIT; out_valid=1 only in SHOW.
REQ-020 SHALL transition IDLE->SHOW at an edge where count!=0, else stay in IDLE.
REQ-021 SHALL stay in SHOW without a pop; on a pop SHALL transition SHOW->WAIT.
REQ-022 SHALL transition WAIT->SHOW if count!=0 at that edge, else WAIT->IDLE.
REQ-023 SHALL give a push into an empty FIFO accepted at edge N out_valid=1 after edge N+1 (latency 1 cycle).
REQ-024 SHALL sustain a throughput of one pop per 2 cycles and one push per cycle.
REQ-025 SHALL ignore a push attempted when full: no memory write, pointers and count unchanged, in_ready=0.
REQ-026 SHALL accept a push while full in the same cycle as a pop: in_ready stays 0 that cycle and the push is accepted the next cycle.
REQ-027 SHALL never write the address under rd_ptr while that entry is unread, which is guaranteed by full gating.

Reset
REQ-028 SHALL, on rst=1 at an edge, set wr_ptr=0, rd_ptr=0, count=0, FSM=IDLE, ovf_err=0 and unf_err=0.
REQ-029 SHALL give reset priority over simultaneous push/pop; data in flight is discarded and memory contents are don't-care.
REQ-030 SHALL, after reset, present out_valid=0, out_data=0, in_ready=1, empty=1, full=0 and count=0.

Configuration
REQ-031 SHALL, when FIFO_ERR_FLAGS_EN is defined, set ovf_err on in_valid & full and set unf_err on out_ready & !out_valid & (FSM==IDLE), both sticky until rst.
REQ-032 SHALL, when FIFO_ERR_FLAGS_EN is undefined, keep ovf_err and unf_err ports present and tie both to 0 with no flag logic.

Verification
REQ-033 SHALL check: reset, then push 4'hA with out_ready=0 -> out_valid=1 one cycle later, out_data=4'hA, count=1.
REQ-034 SHALL check: 8 pushes 1..8 with out_ready=0 -> full=1, in_ready=0; a 9th push 4'hF is dropped and the pop order is 1..8 with no 4'hF.
REQ-035 SHALL check: 20 pushes and pops interleaved -> pointers wrap correctly and data order is preserved.
REQ-036 SHALL check: push and pop in the same cycle at count=3 -> count stays 3, mem_wr_a=1 and rd_ptr advances.
REQ-037 SHALL check: rst asserted mid-stream with count=5 -> next cycle count=0, out_valid=0, in_ready=1.
REQ-038 SHALL check: with FIFO_ERR_FLAGS_EN, in_valid while full -> ovf_err=1 held until rst; without the macro, ovf_err stays 0.

Source files
------------

// File: rtl/dpram_fifo_ctrl_if.sv
// Stream and memory-port bundle for the dual-port-RAM FIFO controller.
// master is the controller's view; slave is the producer/consumer/RAM side.
interface dpram_fifo_ctrl_if #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 3
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;
    logic              mem_wr_a;
    logic [ADDR_W-1:0] mem_addr_a;
    logic [DATA_W-1:0] mem_a;
    logic              mem_wr_b;
    logic [ADDR_W-1:0] mem_addr_b;
    logic [DATA_W-1:0] mem_b;
    logic [DATA_W-1:0] mem_d;

    modport master (
        input  in_valid, in_data, out_ready, mem_d,
        output in_ready, out_valid, out_data,
        output mem_wr_a, mem_addr_a, mem_a,
        output mem_wr_b, mem_addr_b, mem_b
    );

    modport slave (
        output in_valid, in_data, out_ready, mem_d,
        input  in_ready, out_valid, out_data,
        input  mem_wr_a, mem_addr_a, mem_a,
        input  mem_wr_b, mem_addr_b, mem_b
    );
endinterface

// File: rtl/dpram_fifo_ctrl.sv
// FIFO controller around an external 8x4 dual-port RAM (port A writes, port B registered reads).
// Define FIFO_ERR_FLAGS_EN to enable the sticky ovf_err/unf_err flags; otherwise they read 0.
module dpram_fifo_ctrl #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    dpram_fifo_ctrl_if.master bus,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic              ovf_err,
    output logic              unf_err
);

    localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              show;
    logic              push;
    logic              pop;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);

    // Full gating alone protects the unread entry under rd_ptr from being overwritten.
    assign bus.in_ready   = ~full;
    assign push           = bus.in_valid & bus.in_ready;
    assign pop            = show & bus.out_ready;

    assign bus.mem_wr_a   = push;
    assign bus.mem_addr_a = wr_ptr;
    assign bus.mem_a      = bus.in_data;
    assign bus.mem_wr_b   = 1'b0;
    assign bus.mem_addr_b = rd_ptr;
    assign bus.mem_b      = '0;

    assign bus.out_valid  = show;
    assign bus.out_data   = show ? bus.mem_d : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // WAIT gives the RAM one edge to register the entry at the advanced rd_ptr.
    always_comb begin
        state_nxt = state;
        show      = 1'b0;
        unique case (state)
            IDLE: begin
                if (count != '0) state_nxt = SHOW;
            end
            SHOW: begin
                show = 1'b1;
                if (bus.out_ready) state_nxt = WAIT;
            end
            WAIT: begin
                state_nxt = (count != '0) ? SHOW : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef FIFO_ERR_FLAGS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_err <= 1'b0;
            unf_err <= 1'b0;
        end else begin
            if (bus.in_valid & full)                        ovf_err <= 1'b1;
            if (bus.out_ready & ~show & (state == IDLE))    unf_err <= 1'b1;
        end
    end
`else
    assign ovf_err = 1'b0;
    assign unf_err = 1'b0;
`endif

    property p_count_bounded;
        @(posedge clk) disable iff (rst) count <= FULL_CNT;
    endproperty
    a_count_bounded: assert property (p_count_bounded);

    property p_no_write_when_full;
        @(posedge clk) disable iff (rst) full |-> !bus.mem_wr_a;
    endproperty
    a_no_write_when_full: assert property (p_no_write_when_full);

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Randomized bench for dpram_fifo_ctrl with a queue-based reference FIFO and a RAM model.
module tb_dpram_fifo_ctrl;

`ifdef FIFO_ERR_FLAGS_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic [3:0] cnt;
    logic       full;
    logic       empty;
    logic       ovf_err;
    logic       unf_err;

    int checks   = 0;
    int failures = 0;

    logic [3:0] q[$];
    logic [3:0] popped_log[$];
    int         wr_cnt;
    int         rd_cnt;
    logic       ovf_m;
    logic       last_wr_a;

    logic [3:0] ram [8];

    dpram_fifo_ctrl_if #(.DATA_W(4), .ADDR_W(3)) ifc ();

    dpram_fifo_ctrl #(.DATA_W(4), .ADDR_W(3)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (ifc),
        .count   (cnt),
        .full    (full),
        .empty   (empty),
        .ovf_err (ovf_err),
        .unf_err (unf_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Dual-port RAM: write on port A, registered read on port B.
    always @(posedge clk) begin
        if (ifc.mem_wr_a) ram[ifc.mem_addr_a] <= ifc.mem_a;
        if (!ifc.mem_wr_b) ifc.mem_d <= ram[ifc.mem_addr_b];
    end

    task automatic model_clear();
        q.delete();
        wr_cnt = 0;
        rd_cnt = 0;
        ovf_m  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        ifc.in_valid  = 1'b0;
        ifc.in_data   = 4'h0;
        ifc.out_ready = 1'b0;
        model_clear();
    endtask

    // One clock cycle: drive, check against the model, take the edge, update the model.
    task automatic drive_cycle(input logic v, input logic [3:0] d, input logic r);
        logic exp_push;
        logic obs_pop;
        int   pre_size;
        ifc.in_valid  = v;
        ifc.in_data   = d;
        ifc.out_ready = r;
        #1;
        pre_size = q.size();
        exp_push = v && (pre_size != 8);

        checks++;
        if (ifc.in_ready !== (pre_size != 8)) begin
            failures++;
            $display("FAIL in_ready got=%b exp=%b", ifc.in_ready, (pre_size != 8));
        end
        checks++;
        if (cnt !== 4'(pre_size)) begin
            failures++;
            $display("FAIL count got=%0d exp=%0d", cnt, pre_size);
        end
        checks++;
        if (full !== (pre_size == 8) || empty !== (pre_size == 0)) begin
            failures++;
            $display("FAIL full_empty got=%b%b exp=%b%b", full, empty, (pre_size == 8), (pre_size == 0));
        end
        checks++;
        if (ifc.mem_addr_a !== 3'(wr_cnt % 8) || ifc.mem_addr_b !== 3'(rd_cnt % 8)) begin
            failures++;
            $display("FAIL pointers got=%0d/%0d exp=%0d/%0d", ifc.mem_addr_a, ifc.mem_addr_b, wr_cnt % 8, rd_cnt % 8);
        end
        checks++;
        if (ifc.mem_wr_a !== exp_push || ifc.mem_a !== d) begin
            failures++;
            $display("FAIL mem_write got=%b,%h exp=%b,%h", ifc.mem_wr_a, ifc.mem_a, exp_push, d);
        end
        checks++;
        if (ifc.mem_wr_b !== 1'b0 || ifc.mem_b !== 4'h0) begin
            failures++;
            $display("FAIL port_b_tie got=%b,%h exp=0,0", ifc.mem_wr_b, ifc.mem_b);
        end
        checks++;
        if (ifc.out_valid === 1'b1) begin
            if (pre_size == 0) begin
                failures++;
                $display("FAIL valid_on_empty got=1 exp=0");
            end
        end else if (ifc.out_data !== 4'h0) begin
            failures++;
            $display("FAIL out_data_idle got=%h exp=0", ifc.out_data);
        end
        checks++;
        if (ovf_err !== ovf_m) begin
            failures++;
            $display("FAIL ovf_err got=%b exp=%b", ovf_err, ovf_m);
        end

        obs_pop = (ifc.out_valid === 1'b1) && r && (pre_size != 0);
        if (obs_pop) begin
            checks++;
            if (ifc.out_data !== q[0]) begin
                failures++;
                $display("FAIL pop_data got=%h exp=%h", ifc.out_data, q[0]);
            end
            popped_log.push_back(ifc.out_data);
        end
        last_wr_a = ifc.mem_wr_a;
        if (ERR_EN && v && pre_size == 8) ovf_m = 1'b1;

        @(posedge clk);
        if (obs_pop) begin
            void'(q.pop_front());
            rd_cnt++;
        end
        if (exp_push) begin
            q.push_back(d);
            wr_cnt++;
        end
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && (q.size() != 0 || cnt !== 4'd0); i++)
            drive_cycle(1'b0, 4'h0, 1'b1);
        checks++;
        if (q.size() != 0 || cnt !== 4'd0) begin
            failures++;
            $display("FAIL drain_timeout count=%0d model=%0d exp=0", cnt, q.size());
        end
    endtask

    task automatic test_reset();
        ifc.in_valid  = 1'b1;
        ifc.out_ready = 1'b1;
        do_reset();
        checks++;
        if (ifc.out_valid !== 1'b0 || ifc.out_data !== 4'h0 || ifc.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_stream got=v%b d%h r%b exp=v0 d0 r1", ifc.out_valid, ifc.out_data, ifc.in_ready);
        end
        checks++;
        if (cnt !== 4'd0 || empty !== 1'b1 || full !== 1'b0) begin
            failures++;
            $display("FAIL reset_status got=c%0d e%b f%b exp=c0 e1 f0", cnt, empty, full);
        end
        checks++;
        if (ovf_err !== 1'b0 || unf_err !== 1'b0 || ifc.mem_addr_a !== 3'd0 || ifc.mem_addr_b !== 3'd0) begin
            failures++;
            $display("FAIL reset_regs got=o%b u%b a%0d b%0d exp=0 0 0 0", ovf_err, unf_err, ifc.mem_addr_a, ifc.mem_addr_b);
        end
    endtask

    task automatic test_single_push();
        drive_cycle(1'b1, 4'hA, 1'b0);
        checks++;
        if (ifc.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_early_valid got=%b exp=0", ifc.out_valid);
        end
        drive_cycle(1'b0, 4'h0, 1'b0);
        checks++;
        if (ifc.out_valid !== 1'b1 || ifc.out_data !== 4'hA || cnt !== 4'd1) begin
            failures++;
            $display("FAIL single_push got=v%b d%h c%0d exp=v1 dA c1", ifc.out_valid, ifc.out_data, cnt);
        end
        drain();
    endtask

    task automatic test_full();
        for (int i = 1; i <= 8; i++) drive_cycle(1'b1, 4'(i), 1'b0);
        checks++;
        if (full !== 1'b1 || ifc.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL full_flags got=f%b r%b exp=f1 r0", full, ifc.in_ready);
        end
        popped_log.delete();
        drive_cycle(1'b1, 4'hF, 1'b0);
        checks++;
        if (last_wr_a !== 1'b0 || cnt !== 4'd8) begin
            failures++;
            $display("FAIL full_drop got=wr%b c%0d exp=wr0 c8", last_wr_a, cnt);
        end
        drain();
        checks++;
        if (popped_log.size() != 8) begin
            failures++;
            $display("FAIL full_pop_count got=%0d exp=8", popped_log.size());
        end
        for (int i = 0; i < popped_log.size() && i < 8; i++) begin
            checks++;
            if (popped_log[i] !== 4'(i + 1)) begin
                failures++;
                $display("FAIL full_pop_order idx=%0d got=%h exp=%h", i, popped_log[i], 4'(i + 1));
            end
        end
    endtask

    task automatic test_wrap();
        int n = 0;
        int start_wr = wr_cnt;
        for (int i = 0; i < 120 && (n < 20 || q.size() != 0); i++) begin
            if (n < 20 && q.size() != 8) n++;
            drive_cycle(n <= 20 && (wr_cnt - start_wr) < 20, 4'($urandom), 1'b1);
        end
        checks++;
        if (wr_cnt - start_wr != 20 || q.size() != 0) begin
            failures++;
            $display("FAIL wrap_pushes got=%0d left=%0d exp=20 left=0", wr_cnt - start_wr, q.size());
        end
        for (int i = 0; i < 300; i++)
            drive_cycle(1'($urandom_range(0, 1)), 4'($urandom), 1'($urandom_range(0, 1)));
        drain();
    endtask

    task automatic test_simul();
        logic [2:0] rd0;
        for (int i = 0; i < 3; i++) drive_cycle(1'b1, 4'(i + 3), 1'b0);
        for (int i = 0; i < 5 && ifc.out_valid !== 1'b1; i++) drive_cycle(1'b0, 4'h0, 1'b0);
        checks++;
        if (ifc.out_valid !== 1'b1 || cnt !== 4'd3) begin
            failures++;
            $display("FAIL simul_setup got=v%b c%0d exp=v1 c3", ifc.out_valid, cnt);
        end
        rd0 = ifc.mem_addr_b;
        drive_cycle(1'b1, 4'h7, 1'b1);
        checks++;
        if (last_wr_a !== 1'b1 || cnt !== 4'd3 || ifc.mem_addr_b !== rd0 + 3'd1) begin
            failures++;
            $display("FAIL simul_push_pop got=wr%b c%0d rd%0d exp=wr1 c3 rd%0d", last_wr_a, cnt, ifc.mem_addr_b, rd0 + 3'd1);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) drive_cycle(1'b1, 4'($urandom), 1'b0);
        checks++;
        if (cnt !== 4'd5) begin
            failures++;
            $display("FAIL midrst_setup got=%0d exp=5", cnt);
        end
        ifc.in_valid  = 1'b1;
        ifc.out_ready = 1'b1;
        do_reset();
        checks++;
        if (cnt !== 4'd0 || ifc.out_valid !== 1'b0 || ifc.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL midrst got=c%0d v%b r%b exp=c0 v0 r1", cnt, ifc.out_valid, ifc.in_ready);
        end
    endtask

    task automatic test_err_flags();
        do_reset();
        for (int i = 0; i < 8; i++) drive_cycle(1'b1, 4'($urandom), 1'b0);
        drive_cycle(1'b1, 4'hF, 1'b0);
        checks++;
        if (ovf_err !== ERR_EN) begin
            failures++;
            $display("FAIL ovf_set got=%b exp=%b", ovf_err, ERR_EN);
        end
        drain();
        for (int i = 0; i < 3; i++) drive_cycle(1'b0, 4'h0, 1'b1);
        checks++;
        if (ovf_err !== ERR_EN || unf_err !== ERR_EN) begin
            failures++;
            $display("FAIL err_sticky got=o%b u%b exp=%b", ovf_err, unf_err, ERR_EN);
        end
        do_reset();
        checks++;
        if (ovf_err !== 1'b0 || unf_err !== 1'b0) begin
            failures++;
            $display("FAIL err_clear got=o%b u%b exp=0 0", ovf_err, unf_err);
        end
    endtask

    initial begin
        rst           = 1'b1;
        ifc.in_valid  = 1'b0;
        ifc.in_data   = 4'h0;
        ifc.out_ready = 1'b0;
        model_clear();
        last_wr_a = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_single_push();
        test_full();
        test_wrap();
        test_simul();
        test_reset_mid();
        test_err_flags();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
